// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg -- shared opcodes, sweep sizing and FSM state type for the ALU sweep checker (rev 1.0)
`default_nettype none

package alu_chk_pkg;

  localparam int VEC_W   = 12;
  localparam int NUM_VEC = 4096;
  localparam int ERR_W   = 13;

  localparam logic [VEC_W-1:0] LAST_VEC = 12'hFFF;
  localparam logic [ERR_W-1:0] ERR_MAX  = 13'(NUM_VEC);

  localparam logic [2:0] OP_ADDC  = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_NEG   = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_sweep_checker_ref.sv
// alu_ref_model -- combinational golden model of the 4-bit ALU under test (rev 1.0)
`default_nettype none

module alu_ref_model
  import alu_chk_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic [2:0] op,
  output logic [3:0] exp_out,
  output logic       exp_c_out
);

  logic [4:0] sum;

  always_comb begin
    sum = 5'd0;
    case (op)
      OP_ADDC:  sum = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
      OP_SUB:   sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
      OP_INC:   sum = {1'b0, a} + 5'd1;
      OP_DEC:   sum = {1'b0, a} + 5'd15;
      OP_NEG:   sum = {1'b0, ~b} + 5'd1;
      OP_ADD:   sum = {1'b0, a} + {1'b0, b};
      OP_PASSA: sum = {1'b0, a};
      OP_PASSB: sum = {1'b0, b};
      default:  sum = 5'd0;
    endcase
  end

  assign exp_out   = sum[3:0];
  assign exp_c_out = sum[4];

endmodule

`default_nettype wire

// File: rtl/alu_sweep_checker.sv
// alu_sweep_checker -- drives all 4096 {a,b,op,c_in} vectors into an ALU and tallies mismatches (rev 1.0)
`default_nettype none

module alu_sweep_checker
  import alu_chk_pkg::*;
#(
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_c_in,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_out,
  input  logic             alu_c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  state_t           state;
  state_t           state_nxt;
  logic             accept_start;
  logic [VEC_W-1:0] drv_vec;
  logic [VEC_W-1:0] cap_vec;
  logic [3:0]       cap_out;
  logic             cap_c_out;
  logic             cap_valid;
  logic [3:0]       exp_out;
  logic             exp_c_out;
  logic             fail_now;

  // The ALU result is captured alongside its vector, then judged one cycle later.
  alu_ref_model u_ref (
    .a         (cap_vec[11:8]),
    .b         (cap_vec[7:4]),
    .c_in      (cap_vec[0]),
    .op        (cap_vec[3:1]),
    .exp_out   (exp_out),
    .exp_c_out (exp_c_out)
  );

  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);
  assign pass     = done && (err_count == '0);
  assign fail_now = busy && cap_valid && ((cap_out != exp_out) || (cap_c_out != exp_c_out));

  assign {alu_a, alu_b, alu_op, alu_c_in} = drv_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_RUN;
          accept_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (STOP_ON_FAIL && fail_now) state_nxt = ST_DONE;
        else if (drv_vec == LAST_VEC) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE: begin
        if (start) begin
          state_nxt    = ST_RUN;
          accept_start = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drv_vec          <= '0;
      cap_vec          <= '0;
      cap_out          <= '0;
      cap_c_out        <= 1'b0;
      cap_valid        <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      cap_valid <= (state == ST_RUN);
      cap_vec   <= drv_vec;
      cap_out   <= alu_out;
      cap_c_out <= alu_c_out;
      if (accept_start) begin
        drv_vec          <= '0;
        err_count        <= '0;
        first_fail_vec   <= '0;
        first_fail_valid <= 1'b0;
      end else begin
        // Hold the last driven vector when leaving RUN so DONE shows where the sweep stopped.
        if ((state == ST_RUN) && (state_nxt == ST_RUN)) drv_vec <= drv_vec + 12'd1;
        if (fail_now) begin
          if (err_count != ERR_MAX) err_count <= err_count + 13'd1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= cap_vec;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sweep_checker.sv
// tb_alu_sweep_checker -- scoreboard bench: two checkers (STOP_ON_FAIL 0/1) against a fault-injectable ALU
`default_nettype none

module tb_alu_sweep_checker;

  typedef struct {
    int lat;
    int busy_cyc;
    int err;
    int ffv;
    int ffval;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   fault = 0;
  int   errors = 0;
  int   checks = 0;
  int   edges = 0;

  logic [3:0]  a0, b0, out0, a1, b1, out1;
  logic [2:0]  op0, op1;
  logic        ci0, co0, ci1, co1;
  logic        busy0, done0, pass0, ffval0, busy1, done1, pass1, ffval1;
  logic [12:0] err0, err1;
  logic [11:0] ffv0, ffv1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic ci, input int f);
    logic [4:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b} + {4'd0, ci};
      3'd1:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'd2:    r = {1'b0, a} + 5'd1;
      3'd3:    r = {1'b0, a} + 5'd15;
      3'd4:    r = {1'b0, ~b} + 5'd1;
      3'd5:    r = {1'b0, a} + {1'b0, b};
      3'd6:    r = {1'b0, a};
      default: r = {1'b0, b};
    endcase
    if (f == 1 && op == 3'd7) r = {1'b0, a};
    if (f == 2 && op == 3'd6) r[4] = ~r[4];
    return r;
  endfunction

  always_comb {co0, out0} = alu_fn(a0, b0, op0, ci0, fault);
  always_comb {co1, out1} = alu_fn(a1, b1, op1, ci1, fault);

  alu_sweep_checker #(.STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(a0), .alu_b(b0), .alu_c_in(ci0), .alu_op(op0),
    .alu_out(out0), .alu_c_out(co0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  alu_sweep_checker #(.STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(a1), .alu_b(b1), .alu_c_in(ci1), .alu_op(op1),
    .alu_out(out1), .alu_c_out(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitors: latency and busy length are measured from the first cycle busy is seen high.
  int   t0 = 0, bc0 = 0, t1 = 0, bc1 = 0;
  logic pd0 = 1'b0, pb0 = 1'b0, pd1 = 1'b0, pb1 = 1'b0;

  always @(negedge clk) begin
    if (busy0 === 1'b1 && pb0 !== 1'b1) begin bc0 = 0; t0 = edges; end
    if (busy0 === 1'b1) bc0++;
    if (done0 === 1'b1 && pd0 !== 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 done with no expectation queued");
      end else begin
        e0 = q0.pop_front();
        check("dut0 latency", edges - t0, e0.lat);
        check("dut0 busy cycles", bc0, e0.busy_cyc);
        check("dut0 err_count", int'(err0), e0.err);
        check("dut0 first_fail_vec", int'(ffv0), e0.ffv);
        check("dut0 first_fail_valid", int'(ffval0), e0.ffval);
        check("dut0 pass", int'(pass0), e0.pass);
      end
    end
    pd0 = done0;
    pb0 = busy0;
  end

  always @(negedge clk) begin
    if (busy1 === 1'b1 && pb1 !== 1'b1) begin bc1 = 0; t1 = edges; end
    if (busy1 === 1'b1) bc1++;
    if (done1 === 1'b1 && pd1 !== 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 done with no expectation queued");
      end else begin
        e1 = q1.pop_front();
        check("dut1 latency", edges - t1, e1.lat);
        check("dut1 busy cycles", bc1, e1.busy_cyc);
        check("dut1 err_count", int'(err1), e1.err);
        check("dut1 first_fail_vec", int'(ffv1), e1.ffv);
        check("dut1 first_fail_valid", int'(ffval1), e1.ffval);
        check("dut1 pass", int'(pass1), e1.pass);
      end
    end
    pd1 = done1;
    pb1 = busy1;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both_done(input string name);
    int n = 0;
    while (!(done0 === 1'b1 && done1 === 1'b1) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for done (done0=%0b done1=%0b)", name, done0, done1);
    end
    @(negedge clk);
  endtask

  task automatic run_sweep(input string name, input exp_t x0, input exp_t x1, input bit repulse);
    q0.push_back(x0);
    q1.push_back(x1);
    pulse_start();
    if (repulse) begin
      repeat (9) @(negedge clk);
      pulse_start();
      repeat (1989) @(negedge clk);
      pulse_start();
    end
    wait_both_done(name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy0"}, int'(busy0), 0);
    check({tag, " done0"}, int'(done0), 0);
    check({tag, " pass0"}, int'(pass0), 0);
    check({tag, " err0"}, int'(err0), 0);
    check({tag, " ffv0"}, int'(ffv0), 0);
    check({tag, " ffval0"}, int'(ffval0), 0);
    check({tag, " alu ports0"}, int'({a0, b0, op0, ci0}), 0);
    check({tag, " busy1"}, int'(busy1), 0);
    check({tag, " done1"}, int'(done1), 0);
    check({tag, " alu ports1"}, int'({a1, b1, op1, ci1}), 0);
  endtask

  exp_t golden, f1_0, f1_1, f2_0, f2_1;

  initial begin
    golden = '{lat: 4097, busy_cyc: 4097, err: 0,   ffv: 0,      ffval: 0, pass: 1};
    f1_0   = '{lat: 4097, busy_cyc: 4097, err: 480, ffv: 'h01E, ffval: 1, pass: 0};
    f1_1   = '{lat: 32,   busy_cyc: 32,   err: 1,   ffv: 'h01E, ffval: 1, pass: 0};
    f2_0   = '{lat: 4097, busy_cyc: 4097, err: 512, ffv: 'h00C, ffval: 1, pass: 0};
    f2_1   = '{lat: 14,   busy_cyc: 14,   err: 1,   ffv: 'h00C, ffval: 1, pass: 0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep("golden", golden, golden, 1'b0);
    check("done holds last vector", int'({a0, b0, op0, ci0}), 'hFFF);

    fault = 1;
    run_sweep("op7 returns a", f1_0, f1_1, 1'b0);

    fault = 2;
    run_sweep("op6 c_out inverted", f2_0, f2_1, 1'b0);

    // Abort a sweep with a one-edge reset partway through.
    fault = 0;
    pulse_start();
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("mid-sweep reset");
    @(negedge clk);
    run_sweep("after reset", golden, golden, 1'b0);

    run_sweep("start re-pulsed", golden, golden, 1'b1);

    check("dut0 expectations left", q0.size(), 0);
    check("dut1 expectations left", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sweep_checker.md
ALU_SWEEP_CHECKER -- requirements
Module: alu_sweep_checker

Interface
REQ-001 Parameter STOP_ON_FAIL, default 0; when 1, the sweep ends at the first mismatch.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a full sweep; honoured only in IDLE or DONE.
REQ-005 alu_a, alu_b  output  4 each  operands driven to the ALU under test.
REQ-006 alu_c_in  output  1  carry-in driven to the ALU.
REQ-007 alu_op  output  3  opcode driven to the ALU.
REQ-008 alu_out  input  4  ALU result, combinational from the driven vector.
REQ-009 alu_c_out  input  1  ALU carry-out.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high in DONE; held until the next accepted start or reset.
REQ-012 pass  output  1  valid while done=1; high iff err_count==0.
REQ-013 err_count  output  13  number of mismatching vectors in the current/last sweep.
REQ-014 first_fail_vec  output  12  vector {a,b,op,c_in} of the first mismatch; valid while first_fail_valid=1.
REQ-015 first_fail_valid  output  1  set on first mismatch of a sweep.

Function
REQ-016 Vector encoding SHALL be vec[11:0]={a[3:0],b[3:0],op[2:0],c_in}; sweep order vec=0x000 to 0xFFF ascending, all 4096 vectors.
REQ-017 Expected result SHALL be the low 4 bits of a 5-bit sum, expected c_out its bit 4, per op: 000 a+b+c_in; 001 a+~b+1; 010 a+1; 011 a+4'hF; 100 ~b+1; 101 a+b; 110 a with c_out=0; 111 b with c_out=0. c_in ignored for op!=000.
REQ-018 FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE/DONE with start=1 -> RUN; err_count, first_fail_valid, first_fail_vec, done SHALL clear on that edge.
REQ-020 ALU output ports SHALL be registered; vector k driven in the k-th RUN cycle (vec 0 in first RUN cycle).
REQ-021 Result of vector k SHALL be compared one cycle after it is driven, against the expected value of a registered copy of vector k.
REQ-022 RUN -> DRAIN after vector 0xFFF is driven; DRAIN compares vector 0xFFF, then -> DONE.
REQ-023 Start-sampling edge to done=1 SHALL be exactly 4098 rising edges with STOP_ON_FAIL=0.
REQ-024 Mismatch (out or c_out differs) SHALL increment err_count; first mismatch loads first_fail_vec and sets first_fail_valid; counter never wraps (max 4096).
REQ-025 STOP_ON_FAIL=1: on the compare edge detecting a mismatch, state SHALL go to DONE directly (err_count=1).
REQ-026 start while busy SHALL be ignored.
REQ-027 alu_a/alu_b/alu_op/alu_c_in SHALL hold 0 in IDLE and hold last vector in DONE.

Reset
REQ-028 rst_n=0 at any edge, including mid-sweep, SHALL force IDLE, all outputs 0, internal vector register 0.
REQ-029 First accepted start after reset SHALL run a complete sweep from vec 0.

Structure
REQ-030 Package alu_chk_pkg SHALL hold op encodings (OP_ADDC..OP_PASSB), FSM state enum, VEC_W=12, NUM_VEC=4096.
REQ-031 Expected-value function SHALL be a combinational sub-module alu_ref_model (a,b,c_in,op -> exp_out, exp_c_out).

Verification
REQ-032 Golden-model ALU, start pulse -> busy 4097 cycles, done at edge 4098, err_count=0, pass=1, first_fail_valid=0.
REQ-033 ALU fault: op 111 returns a -> err_count=480, first_fail_vec=0x01E, pass=0.
REQ-034 ALU fault: op 110 c_out inverted -> err_count=512, first_fail_vec=0x00C.
REQ-035 STOP_ON_FAIL=1 with op-111 fault -> done 2 edges after vec 0x01E driven, err_count=1, first_fail_vec=0x01E.
REQ-036 rst_n low for one edge at cycle 100 of sweep -> next cycle busy=0, done=0, err_count=0, alu ports 0; new start completes normal sweep.
REQ-037 start re-pulsed at cycles 10 and 2000 of a sweep -> ignored; done timing unchanged at edge 4098.
